// File: rtl/slice_header_field_writer_pkg.sv
// Shared widths, field-kind encodings and the per-field payload for the slice-header writer.
package slice_header_field_writer_pkg;

  localparam int unsigned ACC_W  = 24;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned LEN_W  = 5;
  localparam int unsigned VAL_W  = 16;
  localparam int unsigned LOG2_W = 4;
  localparam int unsigned BYTE_W = 8;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(16);

  typedef enum logic [1:0] {
    FIELD_RAW       = 2'd0,
    FIELD_FRAME_NUM = 2'd1,
    FIELD_POC_LSB   = 2'd2,
    FIELD_TRAILING  = 2'd3
  } field_kind_e;

  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic [VAL_W-1:0] value;
  } field_bits_t;

  // Saturate a raw (up to 6-bit) length to the widest field the writer packs.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W:0] raw);
    return (raw > (LEN_W+1)'(LEN_MAX)) ? LEN_MAX : LEN_W'(raw);
  endfunction

endpackage

// File: rtl/slice_header_field_writer_field_len_select.sv
// Derives the effective field length and the masked, right-aligned value to be packed.
module slice_header_field_writer_field_len_select
  import slice_header_field_writer_pkg::*;
(
  input  logic [1:0]        i_field_kind,
  input  logic [LEN_W-1:0]  i_field_len,
  input  logic [VAL_W-1:0]  i_field_value,
  input  logic [LOG2_W-1:0] i_log2_fn_m4,
  input  logic [LOG2_W-1:0] i_log2_poc_m4,
  input  logic [CNT_W-1:0]  i_bit_count,
  output field_bits_t       o_field
);

  logic [LEN_W:0]   w_raw_len;
  logic [LEN_W-1:0] w_len;
  logic [VAL_W:0]   w_mask;

  always_comb begin
    w_raw_len = '0;
    case (i_field_kind)
      FIELD_FRAME_NUM: w_raw_len = (LEN_W+1)'(i_log2_fn_m4) + (LEN_W+1)'(4);
      FIELD_POC_LSB:   w_raw_len = (LEN_W+1)'(i_log2_poc_m4) + (LEN_W+1)'(4);
      // Stop bit plus zero padding up to the next byte boundary.
      FIELD_TRAILING:  w_raw_len = (i_bit_count < CNT_W'(8)) ?
                                   ((LEN_W+1)'(8) - (LEN_W+1)'(i_bit_count)) : '0;
      default:         w_raw_len = (LEN_W+1)'(i_field_len);
    endcase
  end

  assign w_len  = clamp_len(w_raw_len);
  assign w_mask = ((VAL_W+1)'(1) << w_len) - (VAL_W+1)'(1);

  always_comb begin
    o_field.len   = w_len;
    o_field.value = i_field_value & w_mask[VAL_W-1:0];
    if (i_field_kind == FIELD_TRAILING) begin
      o_field.value = (w_len == '0) ? '0 : VAL_W'((VAL_W+1)'(1) << (w_len - LEN_W'(1)));
    end
  end

endmodule

// File: rtl/slice_header_field_writer.sv
// MSB-first bit packer for fixed-length slice-header fields with a byte valid/ready output.
// Optional emulation-prevention insertion is enabled by defining EMULATION_PREVENTION_EN.
module slice_header_field_writer
  import slice_header_field_writer_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              field_valid,
  output logic              field_ready,
  input  logic [1:0]        field_kind,
  input  logic [LEN_W-1:0]  field_len,
  input  logic [VAL_W-1:0]  field_value,
  input  logic [LOG2_W-1:0] log2_max_frame_num_minus4,
  input  logic [LOG2_W-1:0] log2_max_pic_order_cnt_lsb_minus4,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              writer_idle
);

  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_bit_count;

  field_bits_t      w_field;
  logic             w_field_ready;
  logic             w_byte_valid;
  logic             w_accept;
  logic             w_pop;
  logic             w_emu;
  logic [CNT_W:0]   w_shamt;
  logic [ACC_W-1:0] w_insert;

  slice_header_field_writer_field_len_select u_field_len_select (
    .i_field_kind  (field_kind),
    .i_field_len   (field_len),
    .i_field_value (field_value),
    .i_log2_fn_m4  (log2_max_frame_num_minus4),
    .i_log2_poc_m4 (log2_max_pic_order_cnt_lsb_minus4),
    .i_bit_count   (r_bit_count),
    .o_field       (w_field)
  );

  assign w_field_ready = (r_bit_count < CNT_W'(8));
  assign w_byte_valid  = !w_field_ready;
  assign w_accept      = field_valid && w_field_ready;
  assign w_pop         = w_byte_valid && byte_ready;

  // Place the new field directly below the pending bits.
  assign w_shamt  = (CNT_W+1)'(ACC_W) - (CNT_W+1)'(r_bit_count) - (CNT_W+1)'(w_field.len);
  assign w_insert = ACC_W'(w_field.value) << w_shamt;

`ifdef EMULATION_PREVENTION_EN
  logic [1:0] r_zero_run;

  assign w_emu = (r_zero_run == 2'd2) && w_byte_valid &&
                 (r_acc[ACC_W-1 -: BYTE_W] <= BYTE_W'(8'h03));

  // Counts consecutive 0x00 data bytes; an inserted 0x03 restarts the run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_zero_run <= '0;
    end else if (w_pop) begin
      if (w_emu) begin
        r_zero_run <= '0;
      end else if (r_acc[ACC_W-1 -: BYTE_W] == '0) begin
        r_zero_run <= (r_zero_run == 2'd2) ? 2'd2 : r_zero_run + 2'd1;
      end else begin
        r_zero_run <= '0;
      end
    end
  end
`else
  assign w_emu = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc       <= '0;
      r_bit_count <= '0;
    end else if (w_accept) begin
      r_acc       <= r_acc | w_insert;
      r_bit_count <= r_bit_count + CNT_W'(w_field.len);
    end else if (w_pop && !w_emu) begin
      r_acc       <= r_acc << BYTE_W;
      r_bit_count <= r_bit_count - CNT_W'(8);
    end
  end

  assign field_ready = w_field_ready;
  assign byte_valid  = w_byte_valid;
  assign byte_out    = w_emu ? BYTE_W'(8'h03) : r_acc[ACC_W-1 -: BYTE_W];
  assign writer_idle = (r_bit_count == '0);

endmodule

// File: tb/tb_slice_header_field_writer.sv
// Self-checking bench for slice_header_field_writer: table vectors, corner sequences, random vs bit-queue model.
module tb_slice_header_field_writer;
  import slice_header_field_writer_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        field_valid;
  logic        field_ready;
  logic [1:0]  field_kind;
  logic [4:0]  field_len;
  logic [15:0] field_value;
  logic [3:0]  log2_fn;
  logic [3:0]  log2_poc;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic        writer_idle;

  always #5 clk = ~clk;

  slice_header_field_writer dut (
    .clk                               (clk),
    .reset_n                           (reset_n),
    .field_valid                       (field_valid),
    .field_ready                       (field_ready),
    .field_kind                        (field_kind),
    .field_len                         (field_len),
    .field_value                       (field_value),
    .log2_max_frame_num_minus4         (log2_fn),
    .log2_max_pic_order_cnt_lsb_minus4 (log2_poc),
    .byte_out                          (byte_out),
    .byte_valid                        (byte_valid),
    .byte_ready                        (byte_ready),
    .writer_idle                       (writer_idle)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: pending bits as a plain queue, MSB first.
  bit m_bits[$];
  int m_zr = 0;

  typedef struct {
    logic [1:0]  kind;
    logic [4:0]  len;
    logic [15:0] val;
    logic [3:0]  fn;
    logic [3:0]  poc;
    int          nb;
    logic [23:0] bytes;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_len(input int kind, input int len, input int fn, input int poc);
    int l;
    case (kind)
      1:       l = fn + 4;
      2:       l = poc + 4;
      3:       l = 8 - m_bits.size();
      default: l = len;
    endcase
    if (l > 16) l = 16;
    return l;
  endfunction

  task automatic model_accept(input logic [1:0] kind, input logic [4:0] len, input logic [15:0] val,
                              input logic [3:0] fn, input logic [3:0] poc);
    int l;
    l = model_len(int'(kind), int'(len), int'(fn), int'(poc));
    if (kind == 2'd3) begin
      for (int i = 0; i < l; i++) m_bits.push_back(i == 0);
    end else begin
      for (int i = l - 1; i >= 0; i--) m_bits.push_back(val[i]);
    end
  endtask

  function automatic logic [7:0] model_data();
    logic [7:0] b = 8'h00;
    for (int i = 0; i < 8; i++) b = {b[6:0], m_bits[i]};
    return b;
  endfunction

  function automatic logic [7:0] model_byte();
    logic [7:0] b = model_data();
`ifdef EMULATION_PREVENTION_EN
    if (m_zr == 2 && b <= 8'h03) return 8'h03;
`endif
    return b;
  endfunction

  task automatic model_pop();
    logic [7:0] b = model_data();
`ifdef EMULATION_PREVENTION_EN
    if (m_zr == 2 && b <= 8'h03) begin
      m_zr = 0;
      return;
    end
`endif
    repeat (8) void'(m_bits.pop_front());
    m_zr = (b == 8'h00) ? ((m_zr < 2) ? m_zr + 1 : 2) : 0;
  endtask

  task automatic send(input logic [1:0] kind, input logic [4:0] len, input logic [15:0] val,
                      input logic [3:0] fn, input logic [3:0] poc);
    int waited = 0;
    @(negedge clk);
    while (!field_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!field_ready) begin
      check("field_ready_timeout", {31'd0, field_ready}, 32'd1);
      return;
    end
    field_kind  = kind;
    field_len   = len;
    field_value = val;
    log2_fn     = fn;
    log2_poc    = poc;
    field_valid = 1'b1;
    @(posedge clk);
    model_accept(kind, len, val, fn, poc);
    #1 field_valid = 1'b0;
  endtask

  task automatic pop(output logic [7:0] got, input bit use_model, input int stall);
    int waited = 0;
    got = 8'h00;
    @(negedge clk);
    while (!byte_valid && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!byte_valid) begin
      check("byte_valid_timeout", {31'd0, byte_valid}, 32'd1);
      return;
    end
    for (int s = 0; s < stall; s++) begin
      check("stall_byte_out", {24'd0, byte_out}, {24'd0, model_byte()});
      check("stall_byte_valid", {31'd0, byte_valid}, 32'd1);
      check("stall_field_ready", {31'd0, field_ready}, 32'd0);
      @(negedge clk);
    end
    got = byte_out;
    if (use_model) check("byte_vs_model", {24'd0, byte_out}, {24'd0, model_byte()});
    byte_ready = 1'b1;
    @(posedge clk);
    model_pop();
    #1 byte_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    m_bits.delete();
    m_zr = 0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  logic [7:0] b;
  logic [7:0] got[$];

  initial begin
    reset_n     = 1'b0;
    field_valid = 1'b0;
    field_kind  = 2'd0;
    field_len   = 5'd0;
    field_value = 16'h0;
    log2_fn     = 4'd0;
    log2_poc    = 4'd0;
    byte_ready  = 1'b0;

    // field, SPS params, expected bytes after the trailing flush
    tbl[0] = '{2'd1, 5'd0,  16'h000A, 4'd0,  4'd0, 1, 24'hA80000};
    tbl[1] = '{2'd2, 5'd0,  16'h03FF, 4'd0,  4'd6, 2, 24'hFFE000};
    tbl[2] = '{2'd0, 5'd20, 16'hFFFF, 4'd0,  4'd0, 3, 24'hFFFF80};
    tbl[3] = '{2'd0, 5'd16, 16'h1234, 4'd0,  4'd0, 3, 24'h123480};
    tbl[4] = '{2'd0, 5'd0,  16'hFFFF, 4'd0,  4'd0, 1, 24'h800000};
    tbl[5] = '{2'd1, 5'd0,  16'hABCD, 4'd15, 4'd0, 3, 24'hABCD80};
    tbl[6] = '{2'd0, 5'd3,  16'h00FF, 4'd0,  4'd0, 1, 24'hF00000};
    tbl[7] = '{2'd2, 5'd0,  16'h0035, 4'd0,  4'd0, 1, 24'h580000};

    #2;
    check("reset_byte_valid", {31'd0, byte_valid}, 32'd0);
    check("reset_byte_out", {24'd0, byte_out}, 32'd0);
    check("reset_field_ready", {31'd0, field_ready}, 32'd1);
    check("reset_writer_idle", {31'd0, writer_idle}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      got.delete();
      send(tbl[i].kind, tbl[i].len, tbl[i].val, tbl[i].fn, tbl[i].poc);
      while (m_bits.size() >= 8) begin
        pop(b, 1'b0, 0);
        got.push_back(b);
      end
      send(2'd3, 5'd0, 16'h0, 4'd0, 4'd0);
      while (m_bits.size() >= 8) begin
        pop(b, 1'b0, 0);
        got.push_back(b);
      end
      check($sformatf("vec%0d_nbytes", i), got.size(), tbl[i].nb);
      for (int j = 0; j < tbl[i].nb && j < got.size(); j++)
        check($sformatf("vec%0d_byte%0d", i, j), {24'd0, got[j]}, {24'd0, tbl[i].bytes[23-8*j -: 8]});
      @(negedge clk);
      check($sformatf("vec%0d_idle", i), {31'd0, writer_idle}, 32'd1);
    end

    // Backpressure: byte held stable, no new field accepted, 1-cycle latency.
    send(2'd0, 5'd16, 16'h1234, 4'd0, 4'd0);
    @(negedge clk);
    check("latency_byte_valid", {31'd0, byte_valid}, 32'd1);
    pop(b, 1'b1, 5);
    check("stall_first", {24'd0, b}, 32'h12);
    pop(b, 1'b1, 0);
    check("stall_second", {24'd0, b}, 32'h34);
    @(negedge clk);
    check("stall_idle", {31'd0, writer_idle}, 32'd1);

    // Emulation prevention sequence from a clean zero run.
    do_reset();
    send(2'd0, 5'd16, 16'h0000, 4'd0, 4'd0);
    pop(b, 1'b0, 0);
    check("emu_b0", {24'd0, b}, 32'h00);
    pop(b, 1'b0, 0);
    check("emu_b1", {24'd0, b}, 32'h00);
    send(2'd0, 5'd8, 16'h0001, 4'd0, 4'd0);
`ifdef EMULATION_PREVENTION_EN
    pop(b, 1'b0, 0);
    check("emu_b2_insert", {24'd0, b}, 32'h03);
`endif
    pop(b, 1'b0, 0);
    check("emu_b_last", {24'd0, b}, 32'h01);
    @(negedge clk);
    check("emu_idle", {31'd0, writer_idle}, 32'd1);

    // Asynchronous reset with 12 bits pending.
    send(2'd0, 5'd12, 16'h0ABC, 4'd0, 4'd0);
    @(negedge clk);
    check("pre_rst_byte_valid", {31'd0, byte_valid}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
    check("rst_field_ready", {31'd0, field_ready}, 32'd1);
    check("rst_writer_idle", {31'd0, writer_idle}, 32'd1);
    m_bits.delete();
    m_zr = 0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_no_byte", {31'd0, byte_valid}, 32'd0);
    end

    // Randomized traffic against the bit-queue model.
    for (int it = 0; it < 400; it++) begin
      @(negedge clk);
      check("rnd_field_ready", {31'd0, field_ready}, {31'd0, m_bits.size() < 8});
      check("rnd_byte_valid", {31'd0, byte_valid}, {31'd0, m_bits.size() >= 8});
      check("rnd_idle", {31'd0, writer_idle}, {31'd0, m_bits.size() == 0});
      if (m_bits.size() >= 8) begin
        pop(b, 1'b1, int'($urandom_range(0, 2)));
      end else begin
        send(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 16'($urandom),
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end
    end
    while (m_bits.size() >= 8) pop(b, 1'b1, 0);
    if (m_bits.size() > 0) send(2'd3, 5'd0, 16'h0, 4'd0, 4'd0);
    while (m_bits.size() >= 8) pop(b, 1'b1, 0);
    @(negedge clk);
    check("rnd_final_idle", {31'd0, writer_idle}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/slice_header_field_writer.md
# slice_header_field_writer

Bit-packing writer for fixed-length slice-header fields. It is the encoder-side counterpart of the u(v) field decode used for frame_num and pic_order_cnt_lsb. It accepts one field per handshake, derives the field length from the SPS log2 parameters or an explicit length, and packs bits MSB-first into a 24-bit accumulator. It emits bytes over a valid/ready interface to the NAL assembly stage and, optionally, inserts emulation-prevention bytes.

## Interface
Parameters: none (widths fixed).
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- field_valid  in  1  field offered
- field_ready  out  1  writer can accept a field
- field_kind  in  2  field kind; encodings are `FIELD_RAW`=0, `FIELD_FRAME_NUM`=1, `FIELD_POC_LSB`=2, `FIELD_TRAILING`=3
- field_len  in  5  bit length, used only for `FIELD_RAW`
- field_value  in  16  field value, right-aligned
- log2_max_frame_num_minus4  in  4  SPS parameter
- log2_max_pic_order_cnt_lsb_minus4  in  4  SPS parameter
- byte_out  out  8  output byte
- byte_valid  out  1  byte_out valid
- byte_ready  in  1  downstream accepts the byte
- writer_idle  out  1  no pending bits (bit_count==0)

## Operation
- State: acc[23:0] (MSB-aligned pending bits), bit_count[4:0] (0..23), zero_run[1:0].
- Effective length L:
  - `FIELD_FRAME_NUM`: log2_max_frame_num_minus4+4.
  - `FIELD_POC_LSB`: log2_max_pic_order_cnt_lsb_minus4+4.
  - `FIELD_RAW`: field_len.
  - `FIELD_TRAILING`: 8-bit_count, value 1 followed by zeros (the rbsp_stop_one_bit plus alignment).
  - L is clamped to 16 in all cases.
- field_value is masked to its low L bits. Bits above L are ignored.
- field_ready = (bit_count < 8). Because bit_count ≤ 7 at acceptance, bit_count+L ≤ 23 and the accumulator never overflows.
- Accept (field_valid && field_ready): acc |= masked_value << (24-bit_count-L); bit_count += L. L=0 is a legal no-op handshake.
- byte_valid = (bit_count ≥ 8); byte_out = acc[23:16], except when an emulation byte is being inserted (see Configuration).
- Pop (byte_valid && byte_ready): acc <<= 8 (zero fill); bit_count -= 8. zero_run becomes min(zero_run+1,2) if the popped byte is 0x00, else 0.
- Accept and pop are mutually exclusive by construction (bit_count <8 vs ≥8). No simultaneous-event arbitration is needed.
- After `FIELD_TRAILING`, bit_count is exactly 8, so one final aligned byte is pending.
- Partial bytes (bit_count 1..7) are never emitted. Upstream must issue `FIELD_TRAILING` to flush them.

## Timing
- Reset values: acc=0, bit_count=0, zero_run=0. Therefore byte_valid=0, byte_out=0x00, field_ready=1, writer_idle=1.
- A field accepted at edge N is visible as byte_valid in the cycle after edge N when bit_count ≥ 8. Latency is 1 cycle.
- byte_out and byte_valid hold stable while byte_valid && !byte_ready (AXI-style; no retraction).
- field_ready is a function of registered bit_count only. There is no combinational path from field_valid or byte_ready.
- Sustained throughput is one byte per cycle while bit_count ≥ 8.
- Reset asserted mid-operation discards all pending bits immediately (asynchronously).

## Configuration
- Macro: EMULATION_PREVENTION_EN.
- Defined:
  - When zero_run==2 and bit_count ≥ 8 and acc[23:16] ≤ 0x03, byte_out=0x03 and byte_valid=1.
  - The pop of that 0x03 does not shift acc or change bit_count. It clears zero_run to 0.
  - The original byte follows on the next handshake.
- Undefined: byte_out always equals acc[23:16]. zero_run logic is removed and bytes pass unmodified.

## Structure
- `FIELD_RAW`, `FIELD_FRAME_NUM`, `FIELD_POC_LSB` and `FIELD_TRAILING` are added to nova_defines.v, next to the slice_header_state constants.
- One combinational sub-module, field_len_select: inputs are field_kind, field_len, the log2 parameters and bit_count; outputs are the clamped L and the masked value.
- The accumulator, counters and handshake logic live in the top module.

## Test plan
- `FIELD_FRAME_NUM`, log2_max_frame_num_minus4=0, value 0xA, then `FIELD_TRAILING` -> byte 0xA8; writer_idle=1 afterwards.
- `FIELD_POC_LSB`, log2_max_pic_order_cnt_lsb_minus4=6 (L=10), value 0x3FF, then `FIELD_TRAILING` -> bytes 0xFF, 0xE0.
- `FIELD_RAW` L=16 value 0x1234 with byte_ready held low 5 cycles -> byte_out 0x12 stable throughout; field_ready=0; then 0x12, 0x34 on release.
- `FIELD_RAW` L=20 value 0xFFFF -> clamped to 16 -> bytes 0xFF, 0xFF.
- With EMULATION_PREVENTION_EN: raw 0x0000 (L=16), raw 0x01 (L=8) -> bytes 0x00, 0x00, 0x03, 0x01. Without the macro -> 0x00, 0x00, 0x01.
- reset_n pulsed low with bit_count=12 pending -> byte_valid=0 and field_ready=1 immediately, with no residual bytes.
